// File: rtl/compress_flag_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : compress_flag_sched_if                                           |
// | Brief   : requester, core and result bundle of the flag-compression        |
// |           scheduler; master = scheduler side, slave = environment side.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface compress_flag_sched_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [42*NUM_REQ-1:0] req_diff_position;
  logic [21*NUM_REQ-1:0] req_diff_flag;
  logic [3*NUM_REQ-1:0]  req_diff_num;

  logic                  core_i_valid;
  logic [41:0]           core_diff_position;
  logic [20:0]           core_diff_flag;
  logic [2:0]            core_diff_num;
  logic                  core_o_valid;
  logic [76:0]           core_flag_data;
  logic [3:0]            core_bytesize;

  logic                  res_valid;
  logic                  res_ready;
  logic [76:0]           res_data;
  logic [3:0]            res_bytesize;
  logic [1:0]            res_id;
  logic                  res_err;

  modport master (
    input  req_valid, req_diff_position, req_diff_flag, req_diff_num,
    input  core_o_valid, core_flag_data, core_bytesize,
    input  res_ready,
    output req_ready,
    output core_i_valid, core_diff_position, core_diff_flag, core_diff_num,
    output res_valid, res_data, res_bytesize, res_id, res_err
  );

  modport slave (
    output req_valid, req_diff_position, req_diff_flag, req_diff_num,
    output core_o_valid, core_flag_data, core_bytesize,
    output res_ready,
    input  req_ready,
    input  core_i_valid, core_diff_position, core_diff_flag, core_diff_num,
    input  res_valid, res_data, res_bytesize, res_id, res_err
  );
endinterface
`default_nettype wire

// File: rtl/compress_flag_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : compress_flag_sched                                              |
// | Brief   : round-robin scheduler sharing one flag-compression core among    |
// |           NUM_REQ requesters; optional WAIT timeout via SCHED_TIMEOUT_EN.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module compress_flag_sched #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  compress_flag_sched_if.master bus
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
    $error("compress_flag_sched: NUM_REQ must be 2..4 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] c_LAST_RST = 2'(NUM_REQ - 1);

  state_t      state_q;
  logic [1:0]  last_grant_q;
  logic        core_i_valid_q;
  logic [41:0] core_pos_q;
  logic [20:0] core_flag_q;
  logic [2:0]  core_num_q;
  logic        res_valid_q;
  logic [76:0] res_data_q;
  logic [3:0]  res_bytesize_q;
  logic [1:0]  res_id_q;

  // Requester operands unpacked into fixed four-entry tables; unused slots read 0
  // so an out-of-range index can never produce a grant.
  logic [41:0] w_pos  [4];
  logic [20:0] w_flag [4];
  logic [2:0]  w_num  [4];
  logic [3:0]  w_valid_pad;

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    if (gi < NUM_REQ) begin : g_used
      assign w_pos[gi]       = bus.req_diff_position[42*gi +: 42];
      assign w_flag[gi]      = bus.req_diff_flag[21*gi +: 21];
      assign w_num[gi]       = bus.req_diff_num[3*gi +: 3];
      assign w_valid_pad[gi] = bus.req_valid[gi];
    end else begin : g_pad
      assign w_pos[gi]       = '0;
      assign w_flag[gi]      = '0;
      assign w_num[gi]       = '0;
      assign w_valid_pad[gi] = 1'b0;
    end
  end

  logic [1:0] w_grant;
  logic [1:0] w_cand;
  logic       w_grant_vld;

  // Walk from the farthest candidate back to last_grant+1 so the nearest valid one wins.
  always_comb begin
    w_grant     = 2'd0;
    w_grant_vld = 1'b0;
    w_cand      = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_cand = 2'((int'(last_grant_q) + k) % NUM_REQ);
      if (w_valid_pad[w_cand]) begin
        w_grant     = w_cand;
        w_grant_vld = 1'b1;
      end
    end
  end

  for (genvar gr = 0; gr < NUM_REQ; gr++) begin : g_ready
    assign bus.req_ready[gr] = (state_q == S_IDLE) && w_grant_vld && (w_grant == 2'(gr));
  end

`ifdef SCHED_TIMEOUT_EN
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] tmo_cnt_q;
  logic       res_err_q;
  logic       w_tmo_expire;

  assign w_tmo_expire = (tmo_cnt_q == c_TMO_LAST);
  assign bus.res_err  = res_err_q;
`else
  assign bus.res_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_grant_q   <= c_LAST_RST;
      core_i_valid_q <= 1'b0;
      core_pos_q     <= '0;
      core_flag_q    <= '0;
      core_num_q     <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      res_bytesize_q <= '0;
      res_id_q       <= '0;
`ifdef SCHED_TIMEOUT_EN
      tmo_cnt_q      <= '0;
      res_err_q      <= 1'b0;
`endif
    end else begin
      core_i_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (w_grant_vld) begin
            core_pos_q     <= w_pos[w_grant];
            core_flag_q    <= w_flag[w_grant];
            core_num_q     <= w_num[w_grant];
            last_grant_q   <= w_grant;
            core_i_valid_q <= 1'b1;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
`ifdef SCHED_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        S_WAIT: begin
          // A strobe in the expiry cycle still counts as a normal completion.
          if (bus.core_o_valid) begin
            res_data_q     <= bus.core_flag_data;
            res_bytesize_q <= bus.core_bytesize;
            res_id_q       <= last_grant_q;
            res_valid_q    <= 1'b1;
            state_q        <= S_HOLD;
`ifdef SCHED_TIMEOUT_EN
            res_err_q      <= 1'b0;
          end else if (w_tmo_expire) begin
            res_data_q     <= '0;
            res_bytesize_q <= '0;
            res_id_q       <= last_grant_q;
            res_valid_q    <= 1'b1;
            res_err_q      <= 1'b1;
            state_q        <= S_HOLD;
          end else begin
            tmo_cnt_q      <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        S_HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.core_i_valid       = core_i_valid_q;
  assign bus.core_diff_position = core_pos_q;
  assign bus.core_diff_flag     = core_flag_q;
  assign bus.core_diff_num      = core_num_q;
  assign bus.res_valid          = res_valid_q;
  assign bus.res_data           = res_data_q;
  assign bus.res_bytesize       = res_bytesize_q;
  assign bus.res_id             = res_id_q;

endmodule
`default_nettype wire

// File: tb/tb_compress_flag_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_compress_flag_sched                                           |
// | Brief   : self-checking bench for compress_flag_sched with a round-robin   |
// |           reference model and a randomised core responder.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_compress_flag_sched;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   m_last = N - 1;
  logic core_auto = 1'b0;
  logic [76:0] core_exp_data = '0;
  logic [3:0]  core_exp_size = '0;
  logic [41:0] op_pos [N];
  logic [20:0] op_flg [N];
  logic [2:0]  op_num [N];

  compress_flag_sched_if #(.NUM_REQ(N)) bus ();
  compress_flag_sched #(.NUM_REQ(N), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    return (g < 0) ? '0 : N'(1 << g);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      op_pos[i] = 42'({$urandom(), $urandom()});
      op_flg[i] = 21'($urandom());
      op_num[i] = 3'($urandom());
      bus.req_diff_position[42*i +: 42] = op_pos[i];
      bus.req_diff_flag[21*i +: 21]     = op_flg[i];
      bus.req_diff_num[3*i +: 3]        = op_num[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    m_last = N - 1;
  endtask

  // Core stand-in: answers each start pulse after a random number of WAIT cycles.
  initial begin
    bus.core_o_valid = 1'b0;
    bus.core_flag_data = '0;
    bus.core_bytesize = '0;
    forever begin
      step();
      if (core_auto && bus.core_i_valid === 1'b1) begin
        step();
        repeat ($urandom_range(0, 3)) step();
        core_exp_data = 77'({$urandom(), $urandom(), $urandom()});
        core_exp_size = 4'($urandom());
        bus.core_flag_data = core_exp_data;
        bus.core_bytesize = core_exp_size;
        bus.core_o_valid = 1'b1;
        step();
        bus.core_o_valid = 1'b0;
      end
    end
  end

  task automatic test_reset();
    rand_ops();
    do_reset();
    total++; if (bus.core_i_valid !== 1'b0) begin bad++; $display("FAIL reset_core_i_valid got=%b want=0", bus.core_i_valid); end
    total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
    total++; if ({bus.res_valid, bus.res_err, bus.res_id, bus.res_bytesize} !== 8'd0) begin
      bad++; $display("FAIL reset_res_ctl got=%b%b%h%h want=0", bus.res_valid, bus.res_err, bus.res_id, bus.res_bytesize); end
    total++; if (bus.res_data !== 77'd0) begin bad++; $display("FAIL reset_res_data got=%h want=0", bus.res_data); end
    total++; if ({bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num} !== 66'd0) begin
      bad++; $display("FAIL reset_core_ops got=%h want=0", {bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num}); end
    bus.req_valid = 3'b111;
    #1;
    total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL reset_first_grant got=%b want=001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_single_job();
    logic [65:0] exp_ops;
    logic [76:0] d;
    logic [3:0]  s;
    do_reset();
    core_auto = 1'b0;
    rand_ops();
    op_num[0] = 3'd2;
    bus.req_diff_num[2:0] = 3'd2;
    exp_ops = {op_pos[0], op_flg[0], op_num[0]};
    bus.req_valid = 3'b001;
    #1;
    total++; if (bus.req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b want=001", bus.req_ready); end
    step();
    bus.req_valid = '0;
    rand_ops();
    #1;
    total++; if (bus.core_i_valid !== 1'b1) begin bad++; $display("FAIL single_issue got=%b want=1", bus.core_i_valid); end
    total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL single_ready_issue got=%b want=0", bus.req_ready); end
    step();
    total++; if (bus.core_i_valid !== 1'b0) begin bad++; $display("FAIL single_pulse_len got=%b want=0", bus.core_i_valid); end
    step();
    total++; if ({bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num} !== exp_ops) begin
      bad++; $display("FAIL single_ops got=%h want=%h", {bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num}, exp_ops); end
    d = 77'({$urandom(), $urandom(), $urandom()});
    s = 4'($urandom());
    bus.core_flag_data = d;
    bus.core_bytesize = s;
    bus.core_o_valid = 1'b1;
    step();
    bus.core_o_valid = 1'b0;
    bus.core_flag_data = ~d;
    total++; if ({bus.res_valid, bus.res_err, bus.res_id, bus.res_bytesize, bus.res_data} !== {1'b1, 1'b0, 2'd0, s, d}) begin
      bad++; $display("FAIL single_result got=%b %b %0d %h %h want=1 0 0 %h %h", bus.res_valid, bus.res_err, bus.res_id, bus.res_bytesize, bus.res_data, s, d); end
    repeat (3) begin
      step();
      total++; if ({bus.res_valid, bus.res_data} !== {1'b1, d}) begin
        bad++; $display("FAIL single_hold got=%b %h want=1 %h", bus.res_valid, bus.res_data, d); end
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL single_release got=%b want=0", bus.res_valid); end
    m_last = 0;
  endtask

  task automatic test_fairness();
    logic [65:0] exp_ops;
    int cyc;
    do_reset();
    core_auto = 1'b1;
    bus.res_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      rand_ops();
      bus.req_valid = 3'b111;
      #1;
      total++; if (bus.req_ready !== onehot(j % N)) begin
        bad++; $display("FAIL fair_grant job=%0d got=%b want=%b", j, bus.req_ready, onehot(j % N)); end
      exp_ops = {op_pos[j % N], op_flg[j % N], op_num[j % N]};
      step();
      total++; if ({bus.core_i_valid, bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num} !== {1'b1, exp_ops}) begin
        bad++; $display("FAIL fair_issue job=%0d got=%b %h want=1 %h", j, bus.core_i_valid, {bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num}, exp_ops); end
      m_last = j % N;
      cyc = 0;
      while (bus.res_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
      total++; if ({bus.res_valid, bus.res_id, bus.res_data, bus.res_bytesize} !== {1'b1, 2'(j % N), core_exp_data, core_exp_size}) begin
        bad++; $display("FAIL fair_result job=%0d got=%b %0d %h %h want=1 %0d %h %h", j, bus.res_valid, bus.res_id, bus.res_data, bus.res_bytesize, j % N, core_exp_data, core_exp_size); end
      step();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_skip();
    logic [N-1:0] masks [3];
    int           exp_g [3];
    int           cyc;
    masks[0] = 3'b001; masks[1] = 3'b101; masks[2] = 3'b101;
    exp_g[0] = 0;      exp_g[1] = 2;      exp_g[2] = 0;
    do_reset();
    core_auto = 1'b1;
    bus.res_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.req_valid = masks[j];
      #1;
      total++; if (bus.req_ready !== onehot(exp_g[j])) begin
        bad++; $display("FAIL skip_grant step=%0d got=%b want=%b", j, bus.req_ready, onehot(exp_g[j])); end
      step();
      bus.req_valid = '0;
      m_last = exp_g[j];
      cyc = 0;
      while (bus.res_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
      total++; if ({bus.res_valid, bus.res_id} !== {1'b1, 2'(exp_g[j])}) begin
        bad++; $display("FAIL skip_res_id step=%0d got=%b %0d want=1 %0d", j, bus.res_valid, bus.res_id, exp_g[j]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [83:0] held;
    int g;
    int cyc;
    core_auto = 1'b1;
    bus.res_ready = 1'b0;
    bus.req_valid = 3'b111;
    g = rr_pick(m_last, 3'b111);
    step();
    m_last = g;
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
    total++; if ({bus.res_valid, bus.res_id} !== {1'b1, 2'(g)}) begin
      bad++; $display("FAIL bp_result got=%b %0d want=1 %0d", bus.res_valid, bus.res_id, g); end
    held = {bus.res_data, bus.res_bytesize, bus.res_id, bus.res_err};
    for (int c = 0; c < 10; c++) begin
      step();
      total++; if ({bus.res_valid, bus.res_data, bus.res_bytesize, bus.res_id, bus.res_err} !== {1'b1, held}) begin
        bad++; $display("FAIL bp_stable cyc=%0d got=%b %h want=1 %h", c, bus.res_valid, {bus.res_data, bus.res_bytesize, bus.res_id, bus.res_err}, held); end
      total++; if ({bus.req_ready, bus.core_i_valid} !== 4'd0) begin
        bad++; $display("FAIL bp_quiet cyc=%0d got=%b %b want=000 0", c, bus.req_ready, bus.core_i_valid); end
    end
    bus.res_ready = 1'b1;
    step();
    g = rr_pick(m_last, 3'b111);
    #1;
    total++; if (bus.req_ready !== onehot(g)) begin bad++; $display("FAIL bp_next_grant got=%b want=%b", bus.req_ready, onehot(g)); end
    step();
    bus.req_valid = '0;
    total++; if (bus.core_i_valid !== 1'b1) begin bad++; $display("FAIL bp_next_issue got=%b want=1", bus.core_i_valid); end
    m_last = g;
    cyc = 0;
    while (bus.res_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
    step();
    bus.res_ready = 1'b0;
  endtask

  task automatic test_spurious();
    logic [76:0] d1;
    logic [3:0]  s1;
    int g;
    core_auto = 1'b0;
    bus.res_ready = 1'b0;
    bus.req_valid = '0;
    step();
    bus.core_flag_data = 77'({$urandom(), $urandom(), $urandom()});
    bus.core_o_valid = 1'b1;
    step();
    bus.core_o_valid = 1'b0;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL spur_idle_res got=%b want=0", bus.res_valid); end
    bus.req_valid = 3'b010;
    g = rr_pick(m_last, 3'b010);
    #1;
    total++; if (bus.req_ready !== onehot(g)) begin bad++; $display("FAIL spur_idle_state got=%b want=%b", bus.req_ready, onehot(g)); end
    step();
    bus.req_valid = '0;
    m_last = g;
    step();
    d1 = 77'({$urandom(), $urandom(), $urandom()});
    s1 = 4'($urandom());
    bus.core_flag_data = d1;
    bus.core_bytesize = s1;
    bus.core_o_valid = 1'b1;
    step();
    bus.core_flag_data = ~d1;
    bus.core_bytesize = ~s1;
    step();
    bus.core_o_valid = 1'b0;
    step();
    total++; if ({bus.res_valid, bus.res_data, bus.res_bytesize, bus.res_id} !== {1'b1, d1, s1, 2'(g)}) begin
      bad++; $display("FAIL spur_hold got=%b %h %h %0d want=1 %h %h %0d", bus.res_valid, bus.res_data, bus.res_bytesize, bus.res_id, d1, s1, g); end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL spur_release got=%b want=0", bus.res_valid); end
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [65:0]  exp_ops;
    logic         rr;
    int g;
    int tries;
    int cyc;
    core_auto = 1'b1;
    bus.res_ready = 1'b0;
    for (int j = 0; j < 25; j++) begin
      g = -1;
      tries = 0;
      while (g < 0 && tries < 20) begin
        rand_ops();
        mask = N'($urandom());
        bus.req_valid = mask;
        g = rr_pick(m_last, mask);
        #1;
        total++; if (bus.req_ready !== onehot(g)) begin
          bad++; $display("FAIL rand_grant job=%0d mask=%b got=%b want=%b", j, mask, bus.req_ready, onehot(g)); end
        if (g >= 0) exp_ops = {op_pos[g], op_flg[g], op_num[g]};
        step();
        tries++;
      end
      if (g < 0) continue;
      bus.req_valid = N'($urandom());
      total++; if ({bus.core_i_valid, bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num} !== {1'b1, exp_ops}) begin
        bad++; $display("FAIL rand_issue job=%0d got=%b %h want=1 %h", j, bus.core_i_valid, {bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num}, exp_ops); end
      m_last = g;
      cyc = 0;
      while (bus.res_valid !== 1'b1 && cyc < 40) begin step(); cyc++; end
      total++; if ({bus.res_valid, bus.res_id, bus.res_err, bus.res_data, bus.res_bytesize} !== {1'b1, 2'(g), 1'b0, core_exp_data, core_exp_size}) begin
        bad++; $display("FAIL rand_result job=%0d got=%b %0d %b %h %h want=1 %0d 0 %h %h", j, bus.res_valid, bus.res_id, bus.res_err, bus.res_data, bus.res_bytesize, g, core_exp_data, core_exp_size); end
      cyc = 0;
      do begin
        rr = 1'($urandom_range(0, 1));
        bus.res_ready = rr;
        #1;
        total++; if (bus.req_ready !== '0) begin bad++; $display("FAIL rand_hold_ready job=%0d got=%b want=0", j, bus.req_ready); end
        step();
        cyc++;
      end while (!rr && cyc < 20);
      bus.res_ready = 1'b0;
    end
    bus.req_valid = '0;
    step();
  endtask

`ifdef SCHED_TIMEOUT_EN
  task automatic test_timeout();
    logic [76:0] d;
    do_reset();
    core_auto = 1'b0;
    bus.req_valid = 3'b001;
    step();
    bus.req_valid = '0;
    step();
    repeat (15) step();
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b want=0", bus.res_valid); end
    step();
    total++; if ({bus.res_valid, bus.res_err, bus.res_id, bus.res_bytesize, bus.res_data} !== {1'b1, 1'b1, 2'd0, 4'd0, 77'd0}) begin
      bad++; $display("FAIL tmo_expire got=%b %b %0d %h %h want=1 1 0 0 0", bus.res_valid, bus.res_err, bus.res_id, bus.res_bytesize, bus.res_data); end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    bus.req_valid = 3'b010;
    step();
    bus.req_valid = '0;
    step();
    repeat (15) step();
    d = 77'({$urandom(), $urandom(), $urandom()});
    bus.core_flag_data = d;
    bus.core_o_valid = 1'b1;
    step();
    bus.core_o_valid = 1'b0;
    total++; if ({bus.res_valid, bus.res_err, bus.res_id, bus.res_data} !== {1'b1, 1'b0, 2'd1, d}) begin
      bad++; $display("FAIL tmo_strobe_wins got=%b %b %0d %h want=1 0 1 %h", bus.res_valid, bus.res_err, bus.res_id, bus.res_data, d); end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    m_last = 1;
  endtask
`else
  task automatic test_no_timeout();
    logic [76:0] d;
    do_reset();
    core_auto = 1'b0;
    bus.req_valid = 3'b001;
    step();
    bus.req_valid = '0;
    repeat (40) step();
    total++; if ({bus.res_valid, bus.res_err} !== 2'b00) begin bad++; $display("FAIL notmo_wait got=%b%b want=00", bus.res_valid, bus.res_err); end
    d = 77'({$urandom(), $urandom(), $urandom()});
    bus.core_flag_data = d;
    bus.core_o_valid = 1'b1;
    step();
    bus.core_o_valid = 1'b0;
    total++; if ({bus.res_valid, bus.res_err, bus.res_data} !== {1'b1, 1'b0, d}) begin
      bad++; $display("FAIL notmo_result got=%b %b %h want=1 0 %h", bus.res_valid, bus.res_err, bus.res_data, d); end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    m_last = 0;
  endtask
`endif

  task automatic test_reset_in_wait();
    core_auto = 1'b0;
    rand_ops();
    bus.req_valid = 3'b111;
    step();
    bus.req_valid = '0;
    step();
    step();
    rst = 1'b1;
    step();
    total++; if ({bus.core_i_valid, bus.req_ready, bus.res_valid, bus.res_err, bus.res_id, bus.res_bytesize} !== 12'd0) begin
      bad++; $display("FAIL rstwait_ctl got=%b %b %b %b %0d %h want=0", bus.core_i_valid, bus.req_ready, bus.res_valid, bus.res_err, bus.res_id, bus.res_bytesize); end
    total++; if ({bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num, bus.res_data} !== 143'd0) begin
      bad++; $display("FAIL rstwait_data got=%h %h want=0", {bus.core_diff_position, bus.core_diff_flag, bus.core_diff_num}, bus.res_data); end
    rst = 1'b0;
    m_last = N - 1;
    bus.req_valid = 3'b110;
    #1;
    total++; if (bus.req_ready !== onehot(rr_pick(m_last, 3'b110))) begin
      bad++; $display("FAIL rstwait_idle got=%b want=%b", bus.req_ready, onehot(rr_pick(m_last, 3'b110))); end
    bus.req_valid = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_diff_position = '0;
    bus.req_diff_flag = '0;
    bus.req_diff_num = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single_job();
    test_fairness();
    test_skip();
    test_backpressure();
    test_spurious();
    test_random();
`ifdef SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
